// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's IF/MA request paths, the arbiter and the shared memory port.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch path
    logic              IF_READ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic [DATA_W-1:0] IF_RDATA;
    logic              IF_BUSYWAIT;
    // Load/store path
    logic [3:0]        MA_READ;
    logic [2:0]        MA_WRITE;
    logic [ADDR_W-1:0] MA_ADDR;
    logic [DATA_W-1:0] MA_WDATA;
    logic [DATA_W-1:0] MA_RDATA;
    logic              MA_BUSYWAIT;
    // Memory side
    logic [3:0]        MEM_READ;
    logic [2:0]        MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_BUSYWAIT;
    logic              MEM_ERR;

    // Arbiter view
    modport slave (
        input  IF_READ, IF_ADDR, MA_READ, MA_WRITE, MA_ADDR, MA_WDATA, MEM_RDATA, MEM_BUSYWAIT,
        output IF_RDATA, IF_BUSYWAIT, MA_RDATA, MA_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, MEM_ERR
    );

    // Core + memory view
    modport master (
        output IF_READ, IF_ADDR, MA_READ, MA_WRITE, MA_ADDR, MA_WDATA, MEM_RDATA, MEM_BUSYWAIT,
        input  IF_RDATA, IF_BUSYWAIT, MA_RDATA, MA_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, MEM_ERR
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one busywait-style memory port between instruction fetch (IF) and load/store (MA).
// MA has priority, but IF is forced after MA_STREAK_MAX consecutive MA grants while it waits.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MA_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [3:0]  IF_RD_CODE    = 4'b1010
) (
    input logic               CLK,
    input logic               RST,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [3:0] StreakMax = 4'(MA_STREAK_MAX);
    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [3:0]        mem_read_q, mem_read_d;
    logic [2:0]        mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic [3:0]        streak_q, streak_d;
    logic [7:0]        timer_q, timer_d;
    logic              mem_err_q, mem_err_d;
    logic              if_done_q, if_done_d;
    logic              ma_done_q, ma_done_d;
    logic              gnt_ma_q, gnt_ma_d;

    logic ma_req;
    logic grant_ma;

    // A simultaneous load+store code is treated as a store.
    assign ma_req   = bus.MA_READ[3] | bus.MA_WRITE[2];
    assign grant_ma = ma_req & ((streak_q < StreakMax) | ~bus.IF_READ);

    // Next-state: grant, command latch, completion/timeout, streak and done flags.
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ma_rdata_d  = ma_rdata_q;
        streak_d    = streak_q;
        timer_d     = timer_q;
        mem_err_d   = mem_err_q;
        if_done_d   = if_done_q;
        ma_done_d   = ma_done_q;
        gnt_ma_d    = gnt_ma_q;

        if (!bus.IF_READ) begin
            streak_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (ma_req || bus.IF_READ) begin
                    state_d  = StIssue;
                    timer_d  = '0;
                    gnt_ma_d = grant_ma;
                    if (grant_ma) begin
                        mem_addr_d = bus.MA_ADDR;
                        if (bus.MA_WRITE[2]) begin
                            mem_write_d = bus.MA_WRITE;
                            mem_read_d  = '0;
                            mem_wdata_d = bus.MA_WDATA;
                        end else begin
                            mem_write_d = '0;
                            mem_read_d  = bus.MA_READ;
                            mem_wdata_d = '0;
                        end
                        if (bus.IF_READ && (streak_q < StreakMax)) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else begin
                        mem_addr_d  = bus.IF_ADDR;
                        mem_read_d  = IF_RD_CODE;
                        mem_write_d = '0;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // Completion and timeout share one exit; a still-busy memory here means abort.
                if (!bus.MEM_BUSYWAIT || (timer_q == TimerLast)) begin
                    state_d     = StDone;
                    mem_read_d  = '0;
                    mem_write_d = '0;
                    timer_d     = '0;
                    if (bus.MEM_BUSYWAIT) begin
                        mem_err_d = 1'b1;
                    end
                    // A requester that dropped its request gets neither data nor a done flag.
                    if (gnt_ma_q) begin
                        if (ma_req) begin
                            ma_done_d = 1'b1;
                            if (bus.MEM_BUSYWAIT) begin
                                ma_rdata_d = '0;
                            end else if (mem_read_q[3]) begin
                                ma_rdata_d = bus.MEM_RDATA;
                            end
                        end
                    end else if (bus.IF_READ) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.MEM_BUSYWAIT ? '0 : bus.MEM_RDATA;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StDone: begin
                state_d   = StIdle;
                if_done_d = 1'b0;
                ma_done_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            mem_read_q  <= '0;
            mem_write_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ma_rdata_q  <= '0;
            streak_q    <= '0;
            timer_q     <= '0;
            mem_err_q   <= 1'b0;
            if_done_q   <= 1'b0;
            ma_done_q   <= 1'b0;
            gnt_ma_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ma_rdata_q  <= ma_rdata_d;
            streak_q    <= streak_d;
            timer_q     <= timer_d;
            mem_err_q   <= mem_err_d;
            if_done_q   <= if_done_d;
            ma_done_q   <= ma_done_d;
            gnt_ma_q    <= gnt_ma_d;
        end
    end

    assign bus.MEM_READ    = mem_read_q;
    assign bus.MEM_WRITE   = mem_write_q;
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.MEM_WDATA   = mem_wdata_q;
    assign bus.MEM_ERR     = mem_err_q;
    assign bus.IF_RDATA    = if_rdata_q;
    assign bus.MA_RDATA    = ma_rdata_q;
    // Busywait is high from the first request cycle until the done flag is seen.
    assign bus.IF_BUSYWAIT = bus.IF_READ & ~if_done_q;
    assign bus.MA_BUSYWAIT = ma_req & ~ma_done_q;

endmodule
